hw_jpeg_enc: RTL and testbench
==============================

# hw_jpeg_enc

- Single-channel front end of the JPEG encoder.
- Converts a serial RGB pixel stream to YCbCr and keeps the selected component of one 8x8 block in a 64-entry buffer.
- On command, emits the block in zigzag order as level-shifted samples coded in JPEG amplitude form: a category plus additional bits.
- Sits between the pixel source and the DCT/entropy stages; the color-conversion sub-function is internal to this block.

## Interface
Parameters: none.
- clock  in  1  single clock, rising edge
- reset_n  in  1  reset, synchronous active-low
- input_1pix_enable  in  1  Red/Green/Blue valid this cycle
- Red, Green, Blue  in  8 each  unsigned pixel components
- chan_sel  in  2  component stored with the pixel: 0=Y, 1=Cb, 2=Cr, 3=Y
- Huffman_start  in  1  start emitting a full block
- output_enable  in  1  downstream ready; advances the emit sequence
- pix_data  out  512  buffer contents; pixel i (raster order) at [8i+7:8i]
- block_ready  out  1  all 64 entries written, block not yet emitted
- busy  out  1  emit sequence in progress
- jpeg_valid  out  1  jpeg_out/jpeg_data_bits carry a new symbol this cycle
- jpeg_out  out  16  additional bits, right-justified, zero-extended
- jpeg_data_bits  out  4  category, 0..8

## Operation
Color conversion (stage 1, registered every cycle):
- Compute each sum as signed 18-bit, then arithmetic shift right by 8 (floor).
- Y = (77R + 150G + 29B) >> 8.
- Cb = ((-43R - 85G + 128B) >> 8) + 128.
- Cr = ((128R - 107G - 21B) >> 8) + 128.
- Saturate each result to 0..255.
- input_1pix_enable and chan_sel are registered alongside the three results.

Buffer write (stage 2):
- When the stage-1 valid is set, block_ready=0 and busy=0:
  - write the selected component to entry wr_ptr;
  - increment wr_ptr (6-bit).
- The write of entry 63 sets block_ready.
- A stage-1 valid arriving while block_ready or busy is set is dropped; pixels are never queued.

Emit:
- Huffman_start with block_ready=1 and busy=0 sets busy and resets the read index k to 0.
- Huffman_start at any other time is ignored.
- Each cycle with busy=1 and output_enable=1:
  - read the entry at zigzag position k (standard T.81 order: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,... ending 61,54,47,55,62,63);
  - form s = value - 128 (signed 9-bit);
  - register jpeg_data_bits = smallest n with |s| < 2^n (0 for s=0);
  - register jpeg_out = s if s ≥ 0, else (s - 1) masked to n bits;
  - assert jpeg_valid; increment k.
- After the symbol for k=63 is emitted: busy=0, block_ready=0, wr_ptr=0. The buffer contents are retained until overwritten.
- If output_enable=0 while busy: jpeg_valid=0, jpeg_out and jpeg_data_bits hold, k holds.

## Timing
- Reset (reset_n=0 at a rising edge) clears:
  - all stage-1 registers, wr_ptr, k;
  - pix_data entries;
  - block_ready, busy, jpeg_valid, jpeg_out, jpeg_data_bits.
- Reset overrides every other input, including mid-fill and mid-emit. Any partial block is discarded.
- Pixel latency: inputs sampled at edge t, entry updated at edge t+1, visible on pix_data after edge t+1.
- The 64th write and block_ready assert on the same edge.
- Huffman_start is sampled at edge t; busy=1 after t.
- First symbol: with output_enable=1 at edge t+1, jpeg_valid=1 after edge t+1.
- Throughput: one symbol per cycle under continuous output_enable, so a block takes 64 cycles.
- jpeg_valid deasserts after the edge following the k=63 symbol.
- busy and block_ready fall at the same edge that registers the k=63 symbol.
- A new pixel may be accepted one edge later; back-to-back blocks otherwise need no idle cycles.

## Test plan
- Reset: assert reset_n=0 for 2 cycles after random activity -> all outputs 0, pix_data all zero, block_ready=0, busy=0.
- Conversion: R,G,B=255,255,255 -> Y=255, Cb=128, Cr=128. R,G,B=255,0,0 -> Y=76, Cb=85, Cr=255, checked via pix_data entry 0 with chan_sel 0/1/2 on three blocks.
- Full block: feed 64 gray pixels (R=G=B=v) with v=4i in raster order, then Huffman_start with output_enable=1.
  - block_ready rises after the 64th write; 64 consecutive jpeg_valid cycles.
  - Symbol 0: value 0 -> bits=8, out=0x7F. Symbol 1: entry 1, value 4 -> s=-124, bits=7, out=0x03. Symbol 2: entry 8, value 32 -> s=-96, bits=7, out=0x1F.
  - Last symbol: entry 63, value 252 -> s=124, bits=7, out=0x7C.
- Amplitude coding: single-entry checks -> value 128: bits=0, out=0; value 129: bits=1, out=1; value 127: bits=1, out=0; value 255: bits=7, out=0x7F.
- Backpressure: toggle output_enable 1,0,0,1 during emit -> jpeg_valid only on enabled cycles, outputs held, sequence unbroken, exactly 64 symbols.
- Boundaries:
  - Pixels pulsed while block_ready and while busy -> pix_data unchanged.
  - Huffman_start with 63 entries written -> ignored.
  - reset_n=0 at symbol 30 -> busy=0, no further jpeg_valid, next block fills from entry 0.

Source files
------------

// File: rtl/hw_jpeg_enc.sv
// hw_jpeg_enc: RGB->YCbCr front end that buffers one 8x8 block of a
// component and emits it in zigzag order as JPEG amplitude symbols.
module hw_jpeg_enc (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         input_1pix_enable,
  input  logic [7:0]   Red,
  input  logic [7:0]   Green,
  input  logic [7:0]   Blue,
  input  logic [1:0]   chan_sel,
  input  logic         Huffman_start,
  input  logic         output_enable,
  output logic [511:0] pix_data,
  output logic         block_ready,
  output logic         busy,
  output logic         jpeg_valid,
  output logic [15:0]  jpeg_out,
  output logic [3:0]   jpeg_data_bits
);
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
  logic               s1_v_q, s1_v_d;
  logic [1:0]         s1_sel_q, s1_sel_d;
  logic [7:0]         s1_y_q, s1_y_d, s1_cb_q, s1_cb_d, s1_cr_q, s1_cr_d;
  logic [511:0]       pix_q, pix_d;
  logic [5:0]         wr_ptr_q, wr_ptr_d, k_q, k_d;
  logic               block_ready_q, block_ready_d, busy_q, busy_d;
  logic               jv_q, jv_d;
  logic [15:0]        jo_q, jo_d;
  logic [3:0]         jb_q, jb_d;
  logic signed [17:0] r_s, g_s, b_s, y_sum, cb_sum, cr_sum;
  logic [7:0]         wr_val, rd_val;
  logic signed [8:0]  amp_s;
  logic [8:0]         amp_mag;
  logic [3:0]         cat;
  logic [15:0]        amp_ext, amp_out;

  function automatic logic [7:0] sat(input logic signed [17:0] x);
    return x < 18'sd0 ? 8'd0 : x > 18'sd255 ? 8'hFF : x[7:0];
  endfunction

  always_comb begin
    r_s      = $signed({10'b0, Red});
    g_s      = $signed({10'b0, Green});
    b_s      = $signed({10'b0, Blue});
    y_sum    = 18'sd77 * r_s + 18'sd150 * g_s + 18'sd29 * b_s;
    cb_sum   = 18'sd128 * b_s - 18'sd43 * r_s - 18'sd85 * g_s;
    cr_sum   = 18'sd128 * r_s - 18'sd107 * g_s - 18'sd21 * b_s;
    s1_y_d   = sat(y_sum >>> 8);
    s1_cb_d  = sat((cb_sum >>> 8) + 18'sd128);
    s1_cr_d  = sat((cr_sum >>> 8) + 18'sd128);
    s1_v_d   = input_1pix_enable;
    s1_sel_d = chan_sel;
    wr_val   = s1_sel_q == 2'd1 ? s1_cb_q : s1_sel_q == 2'd2 ? s1_cr_q : s1_y_q;
    rd_val   = pix_q[{ZZ[k_q], 3'b0} +: 8];
    amp_s    = $signed({1'b0, rd_val}) - 9'sd128;
    amp_mag  = amp_s[8] ? (~amp_s + 9'd1) : amp_s;
    cat      = 4'd0;
    for (int i = 0; i < 8; i++) if (amp_mag[i]) cat = 4'(i + 1);
    amp_ext  = {{7{amp_s[8]}}, amp_s};
    // negative amplitudes are sent as (s-1) truncated to the category width
    amp_out  = amp_s[8] ? ((amp_ext - 16'd1) & ((16'd1 << cat) - 16'd1)) : amp_ext;
    pix_d         = pix_q;
    wr_ptr_d      = wr_ptr_q;
    k_d           = k_q;
    block_ready_d = block_ready_q;
    busy_d        = busy_q;
    jv_d          = 1'b0;
    jo_d          = jo_q;
    jb_d          = jb_q;
    if (s1_v_q && !block_ready_q && !busy_q) begin
      pix_d[{wr_ptr_q, 3'b0} +: 8] = wr_val;
      wr_ptr_d      = wr_ptr_q + 6'd1;
      block_ready_d = wr_ptr_q == 6'd63;
    end
    if (Huffman_start && block_ready_q && !busy_q) begin
      busy_d = 1'b1;
      k_d    = 6'd0;
    end
    if (busy_q && output_enable) begin
      jv_d = 1'b1;
      jo_d = amp_out;
      jb_d = cat;
      k_d  = k_q + 6'd1;
      if (k_q == 6'd63) begin
        busy_d        = 1'b0;
        block_ready_d = 1'b0;
        wr_ptr_d      = 6'd0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_v_q        <= 1'b0;
      s1_sel_q      <= 2'd0;
      s1_y_q        <= 8'd0;
      s1_cb_q       <= 8'd0;
      s1_cr_q       <= 8'd0;
      pix_q         <= '0;
      wr_ptr_q      <= 6'd0;
      k_q           <= 6'd0;
      block_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      jv_q          <= 1'b0;
      jo_q          <= 16'd0;
      jb_q          <= 4'd0;
    end else begin
      s1_v_q        <= s1_v_d;
      s1_sel_q      <= s1_sel_d;
      s1_y_q        <= s1_y_d;
      s1_cb_q       <= s1_cb_d;
      s1_cr_q       <= s1_cr_d;
      pix_q         <= pix_d;
      wr_ptr_q      <= wr_ptr_d;
      k_q           <= k_d;
      block_ready_q <= block_ready_d;
      busy_q        <= busy_d;
      jv_q          <= jv_d;
      jo_q          <= jo_d;
      jb_q          <= jb_d;
    end
  end

  assign pix_data       = pix_q;
  assign block_ready    = block_ready_q;
  assign busy           = busy_q;
  assign jpeg_valid     = jv_q;
  assign jpeg_out       = jo_q;
  assign jpeg_data_bits = jb_q;
endmodule

// File: tb/tb_hw_jpeg_enc.sv
// tb_hw_jpeg_enc: directed bench for hw_jpeg_enc with a small amplitude model.
module tb_hw_jpeg_enc;
  logic         clock = 1'b0, reset_n = 1'b0, en = 1'b0, start = 1'b0, oe = 1'b0;
  logic [7:0]   r = 8'd0, g = 8'd0, b = 8'd0;
  logic [1:0]   sel = 2'd0;
  logic [511:0] pix_data;
  logic         block_ready, busy, jpeg_valid;
  logic [15:0]  jpeg_out;
  logic [3:0]   jpeg_data_bits;
  int           n_chk = 0, n_pass = 0;
  logic [7:0]   mdl [64];
  logic [3:0]   got_bits [64];
  logic [15:0]  got_out [64];
  localparam int ZZ [64] = '{
    0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  hw_jpeg_enc dut (
    .clock(clock), .reset_n(reset_n), .input_1pix_enable(en),
    .Red(r), .Green(g), .Blue(b), .chan_sel(sel),
    .Huffman_start(start), .output_enable(oe), .pix_data(pix_data),
    .block_ready(block_ready), .busy(busy), .jpeg_valid(jpeg_valid),
    .jpeg_out(jpeg_out), .jpeg_data_bits(jpeg_data_bits)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] vr, input logic [7:0] vg, input logic [7:0] vb, input logic [1:0] s);
    en = 1'b1; r = vr; g = vg; b = vb; sel = s;
    tick();
    en = 1'b0;
  endtask

  function automatic logic [511:0] packed_mdl();
    logic [511:0] p;
    for (int i = 0; i < 64; i++) p[8*i +: 8] = mdl[i];
    return p;
  endfunction

  task automatic amp(input logic [7:0] v, output logic [3:0] nb, output logic [15:0] o);
    int s, m, n;
    s = int'(v) - 128;
    m = s < 0 ? -s : s;
    n = 0;
    while ((1 << n) <= m) n++;
    nb = 4'(n);
    o = 16'(s >= 0 ? s : s + (1 << n) - 1);
  endtask

  task automatic fill;
    for (int i = 0; i < 64; i++) push(mdl[i], mdl[i], mdl[i], 2'd0);
    chk("ready_before_last_write", block_ready, 0);
    tick();
    chk("ready_after_last_write", block_ready, 1);
    chk("fill_pix", pix_data, packed_mdl());
  endtask

  task automatic emit(input bit bp, input int stop_at, output int n);
    bit          en_now;
    logic [15:0] pv_o, eo;
    logic [3:0]  pv_b, eb;
    n = 0;
    start = 1'b1; oe = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_valid", jpeg_valid, 0);
    for (int c = 0; c < 400 && n < stop_at; c++) begin
      en_now = bp ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
      oe = en_now;
      if (bp && c == 8) begin en = 1'b1; r = 8'd7; g = 8'd7; b = 8'd7; sel = 2'd0; end
      if (bp && c == 11) en = 1'b0;
      pv_o = jpeg_out;
      pv_b = jpeg_data_bits;
      tick();
      chk("valid_vs_oe", jpeg_valid, en_now);
      if (jpeg_valid) begin
        amp(mdl[ZZ[n]], eb, eo);
        chk("sym_bits", jpeg_data_bits, eb);
        chk("sym_out", jpeg_out, eo);
        got_bits[n] = jpeg_data_bits;
        got_out[n]  = jpeg_out;
        n++;
        if (n == 64) begin
          chk("end_busy", busy, 0);
          chk("end_ready", block_ready, 0);
        end
      end else begin
        chk("hold_out", jpeg_out, pv_o);
        chk("hold_bits", jpeg_data_bits, pv_b);
      end
    end
    chk("sym_count", n, stop_at);
  endtask

  initial begin
    int n, cnt;
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      en = 1'($urandom); r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      sel = 2'($urandom); start = 1'($urandom); oe = 1'($urandom);
      if (i >= 10) reset_n = 1'b0;
      tick();
    end
    chk("rst_pix", pix_data, 0);
    chk("rst_ready", block_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", jpeg_valid, 0);
    chk("rst_out", jpeg_out, 0);
    chk("rst_bits", jpeg_data_bits, 0);
    en = 1'b0; start = 1'b0; oe = 1'b0;
    tick();
    reset_n = 1'b1;

    begin
      logic [31:0] cv [7] = '{
        {8'd255, 8'd255, 8'd255, 6'd0, 2'd0}, {8'd255, 8'd255, 8'd255, 6'd0, 2'd1},
        {8'd255, 8'd255, 8'd255, 6'd0, 2'd2}, {8'd255, 8'd0, 8'd0, 6'd0, 2'd0},
        {8'd255, 8'd0, 8'd0, 6'd0, 2'd1},     {8'd255, 8'd0, 8'd0, 6'd0, 2'd2},
        {8'd255, 8'd0, 8'd0, 6'd0, 2'd3}
      };
      logic [7:0] ce [7] = '{8'd255, 8'd128, 8'd128, 8'd76, 8'd85, 8'd255, 8'd76};
      for (int i = 0; i < 7; i++) begin
        push(cv[i][31:24], cv[i][23:16], cv[i][15:8], cv[i][1:0]);
        tick();
        chk("conv_entry0", pix_data[7:0], ce[i]);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end
    end

    for (int i = 0; i < 64; i++) mdl[i] = 8'(4 * i);
    fill();
    push(8'd9, 8'd9, 8'd9, 2'd0);
    tick();
    chk("drop_while_ready", pix_data, packed_mdl());
    emit(1'b0, 64, n);
    tick();
    chk("valid_after_last", jpeg_valid, 0);
    chk("s0_bits", got_bits[0], 8);   chk("s0_out", got_out[0], 16'h7F);
    chk("s1_bits", got_bits[1], 7);   chk("s1_out", got_out[1], 16'h03);
    chk("s2_bits", got_bits[2], 7);   chk("s2_out", got_out[2], 16'h1F);
    chk("s63_bits", got_bits[63], 7); chk("s63_out", got_out[63], 16'h7C);

    for (int i = 0; i < 64; i++) mdl[i] = 8'd128;
    mdl[1] = 8'd129; mdl[8] = 8'd127; mdl[16] = 8'd255;
    fill();
    emit(1'b1, 64, n);
    chk("drop_while_busy", pix_data, packed_mdl());
    oe = 1'b1;
    tick();
    chk("bp_valid_after_last", jpeg_valid, 0);
    chk("a128_bits", got_bits[0], 0); chk("a128_out", got_out[0], 0);
    chk("a129_bits", got_bits[1], 1); chk("a129_out", got_out[1], 1);
    chk("a127_bits", got_bits[2], 1); chk("a127_out", got_out[2], 0);
    chk("a255_bits", got_bits[3], 7); chk("a255_out", got_out[3], 16'h7F);

    for (int i = 0; i < 64; i++) mdl[i] = 8'(100 + i);
    for (int i = 0; i < 63; i++) push(mdl[i], mdl[i], mdl[i], 2'd0);
    tick(); tick();
    chk("ready_at_63", block_ready, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored_busy", busy, 0);
    tick();
    chk("start_ignored_valid", jpeg_valid, 0);
    push(mdl[63], mdl[63], mdl[63], 2'd0);
    tick();
    chk("ready_at_64", block_ready, 1);
    emit(1'b0, 30, n);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", block_ready, 0);
    chk("midrst_valid", jpeg_valid, 0);
    chk("midrst_pix", pix_data, 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (jpeg_valid) cnt++;
    end
    chk("midrst_no_symbols", cnt, 0);
    push(8'd200, 8'd200, 8'd200, 2'd0);
    tick();
    chk("refill_from_0", pix_data[15:0], 16'h00C8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
